color_seq_checker: RTL and testbench

COLOR_SEQ_CHECKER -- requirements
Module: color_seq_checker

---
 rtl/color_seq_checker.sv | 103 ++++++++++
 tb/tb_color_seq_checker.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/color_seq_checker.sv
// color_seq_checker: tracks a 12-bit color counter source, locks after LOCK_STEPS good steps,
// flags sequence violations while locked and counts violations and 0xFFF->0x000 wraps.
module color_seq_checker #(
   parameter int LOCK_STEPS = 4,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       red,
   input  logic [3:0]       green,
   input  logic [3:0]       blue,
   input  logic             enable,
   input  logic             src_reset,
   input  logic             clear_counts,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] wrap_count
);
   localparam int GW = $clog2(LOCK_STEPS + 1);

   typedef enum logic [1:0] {HUNT, LOCKED, FAULT} state_t;

   state_t           state_q, state_d;
   logic [11:0]      ref_q, ref_d;
   logic [GW-1:0]    good_q, good_d;
   logic             step_q, srst_q;
   logic             locked_q, locked_d;
   logic             err_pulse_q, err_pulse_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;
   logic [CNT_W-1:0] wrap_count_q, wrap_count_d;
   logic [11:0]      c, nxt_ref, exp_c;
   logic             match, checked, wrap_hit;

   assign c = {red, green, blue};

   always_comb begin
      // 0x771..0x86F are skipped by the source
      nxt_ref     = (ref_q == 12'h770) ? 12'h870 : ref_q + 12'd1;
      exp_c       = srst_q ? 12'h000 : step_q ? nxt_ref : ref_q;
      match       = (c == exp_c);
      checked     = srst_q | step_q;
      wrap_hit    = (state_q == LOCKED) && step_q && !srst_q && (ref_q == 12'hFFF) && (c == 12'h000);
      state_d     = state_q;
      ref_d       = c;
      good_d      = good_q;
      err_pulse_d = 1'b0;
      case (state_q)
         HUNT: begin
            if (!match) begin
               good_d = '0;
            end else if (checked) begin
               state_d = (good_q == GW'(LOCK_STEPS - 1)) ? LOCKED : HUNT;
               good_d  = (good_q == GW'(LOCK_STEPS - 1)) ? '0 : good_q + GW'(1);
            end
         end
         LOCKED: begin
            state_d     = match ? LOCKED : FAULT;
            err_pulse_d = !match;
         end
         FAULT: begin
            state_d = HUNT;
            good_d  = '0;
         end
         default: begin
            state_d = HUNT;
            good_d  = '0;
         end
      endcase
      locked_d     = (state_d == LOCKED);
      err_count_d  = clear_counts ? '0 : (err_pulse_d && !(&err_count_q)) ? err_count_q + CNT_W'(1) : err_count_q;
      wrap_count_d = clear_counts ? '0 : (wrap_hit && !(&wrap_count_q)) ? wrap_count_q + CNT_W'(1) : wrap_count_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= HUNT;
         ref_q        <= '0;
         good_q       <= '0;
         step_q       <= 1'b0;
         srst_q       <= 1'b0;
         locked_q     <= 1'b0;
         err_pulse_q  <= 1'b0;
         err_count_q  <= '0;
         wrap_count_q <= '0;
      end else begin
         state_q      <= state_d;
         ref_q        <= ref_d;
         good_q       <= good_d;
         step_q       <= enable;
         srst_q       <= src_reset;
         locked_q     <= locked_d;
         err_pulse_q  <= err_pulse_d;
         err_count_q  <= err_count_d;
         wrap_count_q <= wrap_count_d;
      end
   end

   assign locked     = locked_q;
   assign err_pulse  = err_pulse_q;
   assign err_count  = err_count_q;
   assign wrap_count = wrap_count_q;
endmodule

// File: tb/tb_color_seq_checker.sv
// tb_color_seq_checker: table-driven vectors plus hand sequences for lock, skip gap, wrap,
// async reset and counter clear/saturation, checked through an expected-result queue.
module tb_color_seq_checker;
   logic       clk, reset, enable, src_reset, clear_counts;
   logic [11:0] col;
   logic       locked, err_pulse;
   logic [7:0] err_count, wrap_count;

   typedef struct {
      logic       s, e, cl;
      logic [11:0] c;
      logic       el, ep;
      logic [7:0] ec, wc;
   } vec_t;

   typedef struct {
      string       nm;
      logic [17:0] o;
   } exp_t;

   vec_t  tbl [11];
   exp_t  sb [$];
   int    errors = 0;
   int    checks = 0;
   logic [7:0] exp_ec = 0;
   logic [7:0] exp_wc = 0;

   color_seq_checker dut (
      .clk(clk), .reset(reset),
      .red(col[11:8]), .green(col[7:4]), .blue(col[3:0]),
      .enable(enable), .src_reset(src_reset), .clear_counts(clear_counts),
      .locked(locked), .err_pulse(err_pulse),
      .err_count(err_count), .wrap_count(wrap_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [17:0] act, input logic [17:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got {locked,err,ec,wc}=%h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic s, input logic e, input logic cl, input logic [11:0] c,
                      input logic el, input logic ep, input logic [7:0] ec, input logic [7:0] wc,
                      input string nm);
      exp_t x;
      @(negedge clk);
      src_reset = s;
      enable = e;
      clear_counts = cl;
      col = c;
      x.nm = nm;
      x.o = {el, ep, ec, wc};
      sb.push_back(x);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      check(x.nm, {locked, err_pulse, err_count, wrap_count}, x.o);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      reset = 1'b0;
      enable = 1'b0;
      src_reset = 1'b0;
      clear_counts = 1'b0;
      #1;
      check("async_reset", {locked, err_pulse, err_count, wrap_count}, 18'h0);
      @(negedge clk);
      reset = 1'b1;
      exp_ec = 0;
      exp_wc = 0;
   endtask

   // Enters from HUNT with good_cnt=0 and no pending step; ends LOCKED with ref = s+4.
   task automatic lock_seq(input logic [11:0] s);
      for (int i = 0; i < 4; i++)
         cyc(0, 1, 0, s + 12'(i), 0, 0, exp_ec, exp_wc, "lock_hunt");
      cyc(0, 0, 0, s + 12'd4, 1, 0, exp_ec, exp_wc, "lock_rise");
   endtask

   task automatic violate(input logic [11:0] r, input logic cl);
      exp_ec = cl ? 8'd0 : (exp_ec == 8'hFF) ? 8'hFF : exp_ec + 8'd1;
      if (cl) exp_wc = 0;
      cyc(0, 0, cl, r ^ 12'h001, 0, 1, exp_ec, exp_wc, "violate");
      cyc(0, 0, 0, r ^ 12'h001, 0, 0, exp_ec, exp_wc, "fault_exit");
   endtask

   initial begin
      tbl[0]  = '{s:0, e:0, cl:0, c:12'h000, el:0, ep:0, ec:0, wc:0};
      tbl[1]  = '{s:1, e:0, cl:0, c:12'h000, el:0, ep:0, ec:0, wc:0};
      tbl[2]  = '{s:0, e:1, cl:0, c:12'h000, el:0, ep:0, ec:0, wc:0};
      tbl[3]  = '{s:0, e:1, cl:0, c:12'h001, el:0, ep:0, ec:0, wc:0};
      tbl[4]  = '{s:0, e:1, cl:0, c:12'h002, el:0, ep:0, ec:0, wc:0};
      tbl[5]  = '{s:0, e:1, cl:0, c:12'h003, el:1, ep:0, ec:0, wc:0};
      tbl[6]  = '{s:0, e:0, cl:0, c:12'h004, el:1, ep:0, ec:0, wc:0};
      tbl[7]  = '{s:0, e:0, cl:0, c:12'h004, el:1, ep:0, ec:0, wc:0};
      tbl[8]  = '{s:0, e:0, cl:0, c:12'h005, el:0, ep:1, ec:1, wc:0};
      tbl[9]  = '{s:0, e:0, cl:0, c:12'h005, el:0, ep:0, ec:1, wc:0};
      tbl[10] = '{s:0, e:0, cl:1, c:12'h005, el:0, ep:0, ec:0, wc:0};
      reset = 1'b0;
      enable = 1'b0;
      src_reset = 1'b0;
      clear_counts = 1'b0;
      col = 12'h000;
      #1;
      check("reset_state", {locked, err_pulse, err_count, wrap_count}, 18'h0);
      @(negedge clk);
      reset = 1'b1;
      foreach (tbl[i])
         cyc(tbl[i].s, tbl[i].e, tbl[i].cl, tbl[i].c, tbl[i].el, tbl[i].ep, tbl[i].ec, tbl[i].wc,
             $sformatf("tbl%0d", i));
      // reset while locked with three recorded errors
      for (int k = 0; k < 3; k++) begin
         lock_seq(12'h100);
         violate(12'h104, 0);
      end
      lock_seq(12'h100);
      check("locked_ec3", {locked, err_pulse, err_count, wrap_count}, {1'b1, 1'b0, 8'd3, 8'd0});
      do_reset();
      // skip from 0x770 to 0x870 is legal
      lock_seq(12'h76B);
      cyc(0, 1, 0, 12'h76F, 1, 0, 0, 0, "gap_hold");
      cyc(0, 1, 0, 12'h770, 1, 0, 0, 0, "gap_770");
      cyc(0, 0, 0, 12'h870, 1, 0, 0, 0, "gap_870");
      do_reset();
      // 0x771 after 0x770 is a violation
      lock_seq(12'h76B);
      cyc(0, 1, 0, 12'h76F, 1, 0, 0, 0, "gap_hold2");
      cyc(0, 1, 0, 12'h770, 1, 0, 0, 0, "gap_770b");
      cyc(0, 0, 0, 12'h771, 0, 1, 1, 0, "gap_771_err");
      cyc(0, 0, 0, 12'h771, 0, 0, 1, 0, "gap_fault");
      cyc(0, 0, 0, 12'h771, 0, 0, 1, 0, "gap_hunt");
      exp_ec = 1;
      // wrap by step counts; wrap by src_reset does not
      lock_seq(12'hFFB);
      cyc(0, 1, 0, 12'hFFF, 1, 0, exp_ec, 0, "wrap_hold");
      cyc(0, 0, 0, 12'h000, 1, 0, exp_ec, 1, "wrap_step");
      exp_wc = 1;
      violate(12'h000, 0);
      lock_seq(12'hFFB);
      cyc(1, 0, 0, 12'hFFF, 1, 0, exp_ec, exp_wc, "srst_hold");
      cyc(0, 0, 0, 12'h000, 1, 0, exp_ec, exp_wc, "srst_nowrap");
      violate(12'h000, 0);
      // color changes without a step
      lock_seq(12'h11F);
      exp_ec = exp_ec + 8'd1;
      cyc(0, 0, 0, 12'h124, 0, 1, exp_ec, exp_wc, "hold_viol");
      cyc(0, 0, 0, 12'h124, 0, 0, exp_ec, exp_wc, "hold_fault");
      // clear wins over a simultaneous violation, then saturate
      lock_seq(12'h200);
      violate(12'h204, 1);
      for (int k = 0; k < 256; k++) begin
         lock_seq(12'h300);
         violate(12'h304, 0);
      end
      check("sat_255", {locked, err_pulse, err_count, wrap_count}, {1'b0, 1'b0, 8'hFF, 8'h00});
      cyc(0, 0, 1, 12'h305, 0, 0, 0, 0, "clear_sat");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
